// File: rtl/dma_pkg.sv
// Shared FSM state type, AXI encodings and width macros for the DMA copy engine.
// Optional feature macro used by this slice: DMA_CHECKSUM_EN (adds checksum_o).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif

package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_FIN
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Whole words left before the next 4 KB page, given the word offset inside the page.
  function automatic logic [15:0] words_to_4k(input logic [9:0] word_off);
    return 16'd1024 - {6'b0, word_off};
  endfunction

endpackage

// File: rtl/dma_burst_buf.sv
// Single-burst word buffer: R beats are pushed in order, W beats pop them in the same order.
module dma_burst_buf #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [31:0]                wdata_i,
  input  logic                       pop_i,
  output logic [31:0]                rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Overflowing pushes and underflowing pops are dropped so a misbehaving slave cannot corrupt state.
  assign do_push = push_i && !clear_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && !clear_i && (count_q != '0);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/axi_dma_copy.sv
// AXI memory-to-memory copy engine: read burst into a buffer, write it back, repeat per chunk.
// Define DMA_CHECKSUM_EN to add checksum_o (XOR of every word written in the current copy).
module axi_dma_copy
  import dma_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int DMA_ID    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [`ADDR_WIDTH-1:0] src_addr_i,
  input  logic [`ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [15:0]            len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [`ID_BITS-1:0]    awid,
  output logic [`ADDR_WIDTH-1:0] awaddr,
  output logic [`LEN_BITS-1:0]   awlen,
  output logic [`SIZE_BITS-1:0]  awsize,
  output logic [1:0]             awburst,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wvalid,
  output logic                   wlast,
  input  logic                   wready,
  input  logic [`ID_BITS-1:0]    bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  output logic [`ID_BITS-1:0]    arid,
  output logic [`ADDR_WIDTH-1:0] araddr,
  output logic [`LEN_BITS-1:0]   arlen,
  output logic [`SIZE_BITS-1:0]  arsize,
  output logic [1:0]             arburst,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [`ID_BITS-1:0]    rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rvalid,
  input  logic                   rlast,
  output logic                   rready
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [31:0]            checksum_o
`endif
);

  localparam int AW = `ADDR_WIDTH;
  localparam int CW = $clog2(BURST_MAX + 1);

  dma_state_e    state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [15:0]   rem_q, rem_d, beats_q, beats_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic          err_q, err_d, err_next, done_q;
  logic [15:0]   beats_c;
  logic          buf_clear, buf_push, buf_pop;
  logic [31:0]   buf_rdata;
  logic [CW-1:0] buf_count;
  logic          unused_ok;

  assign unused_ok = ^{bid, rid, src_addr_i[1:0], dst_addr_i[1:0]};

  // Chunk size is the smallest of what is left, the burst cap and the room before either 4 KB page ends.
  always_comb begin
    beats_c = rem_q;
    if (beats_c > 16'(BURST_MAX))             beats_c = 16'(BURST_MAX);
    if (beats_c > words_to_4k(src_q[11:2]))   beats_c = words_to_4k(src_q[11:2]);
    if (beats_c > words_to_4k(dst_q[11:2]))   beats_c = words_to_4k(dst_q[11:2]);
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    beats_d   = beats_q;
    rcnt_d    = rcnt_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    err_next  = err_q;
    buf_clear = 1'b0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        src_d   = {src_addr_i[AW-1:2], 2'b00};
        dst_d   = {dst_addr_i[AW-1:2], 2'b00};
        rem_d   = len_i;
        err_d   = 1'b0;
        state_d = (len_i == 16'd0) ? S_FIN : S_RD_ADDR;
      end
      S_RD_ADDR: if (arready) begin
        beats_d   = beats_c;
        rcnt_d    = '0;
        buf_clear = 1'b1;
        state_d   = S_RD_DATA;
      end
      S_RD_DATA: if (rvalid) begin
        rcnt_d   = rcnt_q + 16'd1;
        buf_push = (16'(buf_count) < beats_q);
        if (rresp != AXI_RESP_OKAY) err_d = 1'b1;
        // Beats past the expected count are drained until the slave finally raises rlast.
        if (rlast) begin
          if (rcnt_q < beats_q - 16'd1) err_d = 1'b1;
          wcnt_d  = '0;
          state_d = S_WR_ADDR;
        end else if (rcnt_q == beats_q - 16'd1) begin
          err_d = 1'b1;
        end
      end
      S_WR_ADDR: if (awready) state_d = S_WR_DATA;
      S_WR_DATA: if (wready) begin
        buf_pop = 1'b1;
        wcnt_d  = wcnt_q + 16'd1;
        if (wcnt_q == beats_q - 16'd1) state_d = S_WR_RESP;
      end
      S_WR_RESP: if (bvalid) begin
        err_next = err_q | (bresp != AXI_RESP_OKAY);
        err_d    = err_next;
        src_d    = src_q + AW'({beats_q, 2'b00});
        dst_d    = dst_q + AW'({beats_q, 2'b00});
        rem_d    = rem_q - beats_q;
        state_d  = (err_next || rem_d == 16'd0) ? S_FIN : S_RD_ADDR;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      done_q  <= (state_q == S_FIN);
    end
  end

  dma_burst_buf #(.DEPTH(BURST_MAX)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (buf_clear),
    .push_i  (buf_push),
    .wdata_i (rdata),
    .pop_i   (buf_pop),
    .rdata_o (buf_rdata),
    .count_o (buf_count)
  );

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;

  assign arid    = `ID_BITS'(DMA_ID);
  assign araddr  = src_q;
  assign arlen   = `LEN_BITS'(beats_c - 16'd1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (state_q == S_RD_ADDR);
  assign rready  = (state_q == S_RD_DATA);

  assign awid    = `ID_BITS'(DMA_ID);
  assign awaddr  = dst_q;
  assign awlen   = `LEN_BITS'(beats_q - 16'd1);
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (state_q == S_WR_ADDR);
  assign wdata   = buf_rdata;
  assign wstrb   = 4'hF;
  assign wvalid  = (state_q == S_WR_DATA);
  assign wlast   = wvalid && (wcnt_q == beats_q - 16'd1);
  assign bready  = (state_q == S_WR_RESP);

`ifdef DMA_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      csum_q <= '0;
    end else if (wvalid && wready) begin
      csum_q <= csum_q ^ wdata;
    end
  end

  assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_axi_dma_copy.sv
// Bench for axi_dma_copy: AXI slave memory with random stalls, scoreboard of expected bursts and data.
// With DMA_CHECKSUM_EN defined the bench also checks checksum_o.
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif

module tb_axi_dma_copy;

  localparam int BURST_MAX = 16;
  localparam int DMA_ID    = 3;
  localparam int LIMIT     = 6000;

  logic                   clk_i = 1'b0;
  logic                   rst_ni, start_i;
  logic [`ADDR_WIDTH-1:0] src_addr_i, dst_addr_i;
  logic [15:0]            len_i;
  logic                   busy_o, done_o, err_o;
  logic [`ID_BITS-1:0]    awid, arid, bid, rid;
  logic [`ADDR_WIDTH-1:0] awaddr, araddr;
  logic [`LEN_BITS-1:0]   awlen, arlen;
  logic [`SIZE_BITS-1:0]  awsize, arsize;
  logic [1:0]             awburst, arburst, bresp, rresp;
  logic                   awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic                   arvalid, arready, rvalid, rlast, rready;
  logic [31:0]            wdata, rdata;
  logic [3:0]             wstrb;
`ifdef DMA_CHECKSUM_EN
  logic [31:0]            checksum_o;
`endif

  always #5 clk_i = ~clk_i;

  axi_dma_copy #(.BURST_MAX(BURST_MAX), .DMA_ID(DMA_ID)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
`ifdef DMA_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } burst_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;

  int total = 0;
  int bad = 0;

  logic [31:0] mem    [0:16383];
  logic [31:0] refMem [0:16383];

  burst_t expAr[$], expAw[$], arLog[$], awLog[$];
  beat_t  expW[$];
  logic [31:0] expXor;
  int arValidSeen, awValidSeen;

  int  stallPct = 0;
  int  bCount = 0;
  bit  errFirstB = 0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[15:2]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: event happened, expected none", name);
  endtask

  // Reference model: chunk the copy by remaining length, burst cap and both 4 KB pages.
  task automatic buildExpect(input logic [31:0] src, input logic [31:0] dst, input int len, input bit errFirst);
    int rem, b, toS, toD;
    logic [31:0] s, d;
    rem = len;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    expXor = '0;
    while (rem > 0) begin
      toS = (4096 - int'(s % 4096)) / 4;
      toD = (4096 - int'(d % 4096)) / 4;
      b = rem;
      if (b > BURST_MAX) b = BURST_MAX;
      if (b > toS) b = toS;
      if (b > toD) b = toD;
      expAr.push_back('{s, 8'(b - 1)});
      expAw.push_back('{d, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        expW.push_back('{refMem[widx(s) + i], (i == b - 1)});
        expXor ^= refMem[widx(s) + i];
      end
      for (int i = 0; i < b; i++) refMem[widx(d) + i] = refMem[widx(s) + i];
      if (errFirst) break;
      s += 32'(4 * b);
      d += 32'(4 * b);
      rem -= b;
    end
  endtask

  // AXI slave memory: handshakes are captured on the falling edge, responses change just after the rising edge.
  initial begin
    logic hsAr, hsR, hsAw, hsW, hsB, capWlast;
    logic [31:0] capAddr, capWdata, rdAddr, wrAddr;
    logic [7:0]  capLen, rdLen;
    int rdIdx, wrIdx;
    bit rdActive, bPend;
    rdActive = 0; bPend = 0; rdIdx = 0; wrIdx = 0; rdAddr = '0; rdLen = '0; wrAddr = '0;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 0; rid = DMA_ID[`ID_BITS-1:0];
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = DMA_ID[`ID_BITS-1:0];
    forever begin
      @(negedge clk_i);
      hsAr = arvalid && arready; hsR = rvalid && rready; hsAw = awvalid && awready;
      hsW = wvalid && wready; hsB = bvalid && bready;
      capWdata = wdata; capWlast = wlast;
      capAddr = hsAr ? araddr : awaddr;
      capLen  = hsAr ? arlen : awlen;
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        rdActive = 0; bPend = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        continue;
      end
      if (hsAr) begin rdAddr = capAddr; rdLen = capLen; rdIdx = 0; rdActive = 1; end
      if (hsR) begin
        if (rdIdx == int'(rdLen)) rdActive = 0;
        else rdIdx++;
      end
      if (hsAw) begin wrAddr = capAddr; wrIdx = 0; end
      if (hsW) begin
        mem[widx(wrAddr) + wrIdx] = capWdata;
        wrIdx++;
        if (capWlast) bPend = 1;
      end
      if (hsB) begin bPend = 0; bCount++; end
      arready = ($urandom_range(99) >= stallPct);
      awready = ($urandom_range(99) >= stallPct);
      wready  = ($urandom_range(99) >= stallPct);
      if (!(rvalid && !hsR)) rvalid = rdActive && ($urandom_range(99) >= stallPct);
      rdata = mem[widx(rdAddr) + rdIdx];
      rlast = (rdIdx == int'(rdLen));
      if (!(bvalid && !hsB)) bvalid = bPend && ($urandom_range(99) >= stallPct);
      bresp = (errFirstB && bCount == 0) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks payload holds while a valid waits.
  logic        arPend = 0, awPend = 0, wPend = 0;
  logic [39:0] arHold, awHold;
  logic [32:0] wHold;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      arPend = 0; awPend = 0; wPend = 0;
    end else begin
      if (arvalid) arValidSeen++;
      if (awvalid) awValidSeen++;
      if (arPend) checkOutput("ar_hold", {arvalid, araddr, arlen}, {1'b1, arHold});
      if (awPend) checkOutput("aw_hold", {awvalid, awaddr, awlen}, {1'b1, awHold});
      if (wPend)  checkOutput("w_hold", {wvalid, wdata, wlast}, {1'b1, wHold});
      if (arvalid && arready) begin
        arLog.push_back('{araddr, arlen});
        if (expAr.size() == 0) failNote("ar_unexpected");
        else checkOutput("ar_burst", {araddr, arlen}, expAr.pop_front());
        checkOutput("ar_attr", {arsize, arburst, arid}, {3'd2, 2'b01, DMA_ID[`ID_BITS-1:0]});
      end
      if (awvalid && awready) begin
        awLog.push_back('{awaddr, awlen});
        if (expAw.size() == 0) failNote("aw_unexpected");
        else checkOutput("aw_burst", {awaddr, awlen}, expAw.pop_front());
        checkOutput("aw_attr", {awsize, awburst, awid}, {3'd2, 2'b01, DMA_ID[`ID_BITS-1:0]});
      end
      if (wvalid && wready) begin
        if (expW.size() == 0) failNote("w_unexpected");
        else checkOutput("w_beat", {wdata, wlast, wstrb}, {expW.pop_front(), 4'hF});
      end
      arPend = arvalid && !arready; arHold = {araddr, arlen};
      awPend = awvalid && !awready; awHold = {awaddr, awlen};
      wPend  = wvalid && !wready;   wHold  = {wdata, wlast};
    end
  end

  // Issues one copy and returns the number of falling edges from start to done (LIMIT on timeout).
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input bit errFirst, input bit midStart, output int cycles);
    int n;
    arLog.delete(); awLog.delete();
    arValidSeen = 0; awValidSeen = 0; bCount = 0; errFirstB = errFirst;
    buildExpect(src, dst, len, errFirst);
    @(negedge clk_i);
    start_i = 1; src_addr_i = src; dst_addr_i = dst; len_i = 16'(len);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (n == 1) start_i = 0;
      if (midStart && n == 6) begin
        start_i = 1; src_addr_i = 32'h9000; dst_addr_i = 32'hA000; len_i = 16'd5;
      end
      if (midStart && n == 7) start_i = 0;
    end while (!done_o && n < LIMIT);
    if (!done_o) failNote("done_timeout");
    cycles = n;
  endtask

  task automatic checkCopy(input string tag, input logic [31:0] dst, input int len, input bit expErr);
    int mism;
    mism = 0;
`ifdef DMA_CHECKSUM_EN
    if (!expErr) checkOutput({tag, "_checksum"}, checksum_o, expXor);
`endif
    checkOutput({tag, "_err"}, err_o, expErr);
    @(negedge clk_i);
    checkOutput({tag, "_done_width"}, {done_o, busy_o}, 2'b00);
    checkOutput({tag, "_left"}, expAr.size() + expAw.size() + expW.size(), 0);
    for (int i = 0; i < len; i++)
      if (mem[widx(dst & ~32'h3) + i] !== refMem[widx(dst & ~32'h3) + i]) mism++;
    checkOutput({tag, "_dst_words"}, mism, 0);
  endtask

  initial begin
    int cyc;
    logic [31:0] src, dst;
    int len;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      refMem[i] = mem[i];
    end
    rst_ni = 0; start_i = 0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_ctrl", {busy_o, done_o, err_o}, 3'b000);
    checkOutput("reset_axi", {arvalid, awvalid, wvalid, wlast, rready, bready}, 6'b0);
    rst_ni = 1;
    repeat (2) @(negedge clk_i);

    $display("[TB] single 4-word burst");
    applyStimulus(32'h100, 32'h800, 4, 0, 0, cyc);
    checkOutput("t1_bursts", {8'(arLog.size()), 8'(awLog.size())}, {8'd1, 8'd1});
    checkOutput("t1_lens", {arLog[0].len, awLog[0].len}, {8'd3, 8'd3});
    checkCopy("t1", 32'h800, 4, 0);

    $display("[TB] 40 words split 16/16/8");
    applyStimulus(32'h4000, 32'h800, 40, 0, 0, cyc);
    checkOutput("t2_count", awLog.size(), 3);
    if (awLog.size() == 3) begin
      checkOutput("t2_awaddr", {awLog[0].addr, awLog[1].addr, awLog[2].addr}, {32'h800, 32'h840, 32'h880});
      checkOutput("t2_awlen", {awLog[0].len, awLog[1].len, awLog[2].len}, {8'd15, 8'd15, 8'd7});
    end
    checkCopy("t2", 32'h800, 40, 0);

    $display("[TB] source crossing a 4 KB page");
    applyStimulus(32'hFF8, 32'h3000, 4, 0, 0, cyc);
    checkOutput("t3_count", arLog.size(), 2);
    if (arLog.size() == 2) begin
      checkOutput("t3_araddr", {arLog[0].addr, arLog[1].addr}, {32'hFF8, 32'h1000});
      checkOutput("t3_arlen", {arLog[0].len, arLog[1].len}, {8'd1, 8'd1});
    end
    checkCopy("t3", 32'h3000, 4, 0);

    $display("[TB] zero length");
    applyStimulus(32'h200, 32'h900, 0, 0, 0, cyc);
    checkOutput("t4_latency", cyc, 2);
    checkOutput("t4_no_addr", {arValidSeen, awValidSeen}, 64'd0);
    checkCopy("t4", 32'h900, 0, 0);

    $display("[TB] write error on first burst");
    applyStimulus(32'h5000, 32'h6000, 32, 1, 0, cyc);
    checkOutput("t5_ar_count", arLog.size(), 1);
    checkCopy("t5", 32'h6000, 32, 1);

    $display("[TB] random stalls with a second start mid-copy");
    stallPct = 40;
    for (int k = 0; k < 6; k++) begin
      src = 32'h100 + 32'($urandom_range(32'h6000));
      dst = 32'h8000 + 32'($urandom_range(32'h6FFF));
      len = int'($urandom_range(90, 20));
      applyStimulus(src, dst, len, 0, 1, cyc);
      checkCopy("t6", dst, len, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_dma_copy.md
AXI_DMA_COPY -- requirements
Module: axi_dma_copy

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16, maximum beats per AXI burst (2..256).
REQ-002 SHALL have parameter DMA_ID, default 0, constant AXI ID driven on awid/arid.
REQ-003 SHALL have clk_i  in  1  the single clock; rst_ni  in  1  synchronous active-low reset.
REQ-004 SHALL have start_i  in  1  copy request; src_addr_i, dst_addr_i  in  `ADDR_WIDTH  byte addresses; len_i  in  16  length in 32-bit words.
REQ-005 SHALL have busy_o  out  1  copy in progress; done_o  out  1  one-cycle completion pulse; err_o  out  1  sticky error of the last copy.
REQ-006 SHALL have AXI master AW outputs awid, awaddr, awlen, awsize, awburst, awvalid, and input awready, using the `ID_BITS/`ADDR_WIDTH/`LEN_BITS/`SIZE_BITS widths.
REQ-007 SHALL have AXI master W outputs wdata, wstrb, wvalid, wlast, and input wready; B inputs bid, bresp, bvalid, and output bready.
REQ-008 SHALL have AXI master AR outputs arid, araddr, arlen, arsize, arburst, arvalid, and input arready; R inputs rid, rdata, rresp, rvalid, rlast, and output rready.

Function
REQ-009 SHALL run FSM IDLE -> RD_ADDR -> RD_DATA -> WR_ADDR -> WR_DATA -> WR_RESP -> (RD_ADDR if words remain, else FIN) -> IDLE.
REQ-010 SHALL accept start_i only in IDLE: latch addresses with bits [1:0] forced to 0, latch len_i, clear err_o; start_i while busy SHALL be ignored.
REQ-011 SHALL treat len_i=0 as IDLE -> FIN: done_o pulses 2 cycles after start_i with no AXI traffic.
REQ-012 SHALL size each chunk as beats = min(remaining, BURST_MAX, words to next 4 KB boundary of src, words to next 4 KB boundary of dst); arlen = awlen = beats-1.
REQ-013 SHALL drive arsize = awsize = 2 (4 bytes), arburst = awburst = INCR (2'b01), wstrb all ones, rready = 1 in RD_DATA only, bready = 1 in WR_RESP only.
REQ-014 SHALL hold arvalid/awvalid, with stable payload, from state entry until the ready handshake, and never deassert them before that handshake.
REQ-015 SHALL store R beats in an internal buffer of BURST_MAX words in order; the R phase SHALL end on the beat where rlast=1.
REQ-016 SHALL set err_o if rresp != 0, bresp != 0, rlast arrives before the expected beat count, or rlast is absent on the expected last beat; extra beats SHALL be drained and discarded.
REQ-017 SHALL drive wdata from the buffer in order, with wvalid held until wready, and wlast=1 exactly on beat beats-1.
REQ-018 SHALL, after B completes, advance src/dst by beats*4 and reduce remaining by beats; if err_o is set, SHALL go to FIN regardless of remaining.
REQ-019 SHALL pulse done_o for exactly one cycle in FIN; busy_o = 1 in every state except IDLE.
REQ-020 SHALL keep only one AXI transaction outstanding at a time (no read/write overlap).

Reset
REQ-021 SHALL, with rst_ni=0 at a rising clk_i, enter IDLE and clear busy_o, done_o, err_o, arvalid, awvalid, wvalid, wlast, rready, bready, the counters, and the address registers.
REQ-022 SHALL, on reset mid-copy, abandon the copy with no done_o; the interconnect is reset together with this block.

Configuration
REQ-023 SHALL, with `DMA_CHECKSUM_EN defined, add output checksum_o (32 bits): XOR of all words written in the current copy, cleared on accepted start_i, and valid when done_o pulses.
REQ-024 SHALL, without `DMA_CHECKSUM_EN, omit checksum_o and its logic entirely.

Structure
REQ-025 SHALL place the FSM state enum, AXI_BURST_INCR = 2'b01, AXI_SIZE_4B = 3'd2 and AXI_RESP_OKAY = 2'b00 in a shared package dma_pkg.
REQ-026 SHALL implement the burst buffer as one sub-module dma_burst_buf (depth BURST_MAX, write/read pointers, count, clear).

Verification
REQ-027 Bench SHALL cover: src=0x100, dst=0x800, len=4 into SDRAM slave -> one AR (arlen=3), one AW (awlen=3), dst words equal src words, done_o 1 cycle, err_o=0.
REQ-028 Bench SHALL cover: len=40, BURST_MAX=16 -> bursts of 16, 16 and 8 beats; awaddr sequence 0x800, 0x840, 0x880.
REQ-029 Bench SHALL cover: src=0xFF8, len=4 -> read bursts of 2 beats (araddr 0xFF8) then 2 beats (araddr 0x1000); no burst crosses 4 KB.
REQ-030 Bench SHALL cover: len=0 -> no arvalid/awvalid, done_o pulse 2 cycles after start_i.
REQ-031 Bench SHALL cover: slave returns bresp=2'b10 on the first burst of len=32 -> err_o=1, no second AR, done_o pulses.
REQ-032 Bench SHALL cover: random awready/wready/arready/rvalid stalls with start_i pulsed mid-copy -> payload stable while valid is high, second start ignored, data intact; with `DMA_CHECKSUM_EN, checksum_o equals the XOR of the data.
